// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - iterative multiply/divide unit producing {HI,LO} beside the EX-stage ALU
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   start_i           EX holds a mul/div op (held high while stalled)
//   op_i              0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU
//   opa_i, opb_i      rs / rt operands (dividend / divisor)
//   hi_i, lo_i        forwarded HI/LO for the accumulate ops
//   cancel_i          flush of the EX instruction
//   stall_o           pipeline hold request (combinational)
//   done_o, whilo_o   one-cycle completion pulse / HI-LO write enable
//   hi_o, lo_o        result (multiply: product halves; divide: remainder / quotient)
//   dbz_o             divide-by-zero flag, valid with done_o
module ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] opa_i,
  input  logic [DATA_W-1:0] opb_i,
  input  logic [DATA_W-1:0] hi_i,
  input  logic [DATA_W-1:0] lo_i,
  input  logic              cancel_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              whilo_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o,
  output logic              dbz_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

  state_t                r_state;
  state_t                w_next;
  logic [1:0]            r_op;      // op_i[2:1]: signedness lives in r_sa/r_sb
  logic [CNT_W-1:0]      r_cnt;
  logic [2*DATA_W-1:0]   r_acc;     // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [DATA_W-1:0]     r_b;
  logic [DATA_W-1:0]     r_hi;
  logic [DATA_W-1:0]     r_lo;
  logic                  r_sa;
  logic                  r_sb;
  logic                  r_dbz;
  logic [DATA_W-1:0]     r_hi_o;
  logic [DATA_W-1:0]     r_lo_o;

  logic                  w_accept;
  logic                  w_in_signed;
  logic                  w_in_div;
  logic                  w_in_dbz;
  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_W-1:0]     w_mag_a;
  logic [DATA_W-1:0]     w_mag_b;

  logic [DATA_W:0]       w_mul_sum;
  logic [2*DATA_W-1:0]   w_mul_next;
  logic [DATA_W:0]       w_rem_sh;
  logic [DATA_W:0]       w_diff;
  logic [2*DATA_W-1:0]   w_div_next;

  logic                  w_neg_res;
  logic [2*DATA_W-1:0]   w_prod;
  logic [2*DATA_W-1:0]   w_hilo;
  logic [2*DATA_W-1:0]   w_acc_res;
  logic [DATA_W-1:0]     w_quo;
  logic [DATA_W-1:0]     w_rem;
  logic [DATA_W-1:0]     w_fix_hi;
  logic [DATA_W-1:0]     w_fix_lo;

  // ---------------- operand capture ----------------
  assign w_accept    = (r_state == S_IDLE) && start_i && !cancel_i;
  assign w_in_signed = ~op_i[0];
  assign w_in_div    = (op_i[2:1] == 2'b01);
  assign w_in_dbz    = w_in_div && (opb_i == '0);
  assign w_a_neg     = w_in_signed & opa_i[DATA_W-1];
  assign w_b_neg     = w_in_signed & opb_i[DATA_W-1];
  assign w_mag_a     = w_a_neg ? (~opa_i + 1'b1) : opa_i;
  assign w_mag_b     = w_b_neg ? (~opb_i + 1'b1) : opb_i;

  // ---------------- iteration steps ----------------
  // Shift-add: add multiplicand into the upper half when the multiplier LSB
  // is set, then shift the whole {carry, upper, multiplier} right by one.
  assign w_mul_sum  = {1'b0, r_acc[2*DATA_W-1:DATA_W]} +
                      (r_acc[0] ? {1'b0, r_b} : {(DATA_W+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[DATA_W-1:1]};

  // Restoring divide: shift the next dividend bit into the remainder and
  // keep the difference only when it did not borrow.
  assign w_rem_sh   = r_acc[2*DATA_W-1:DATA_W-1];
  assign w_diff     = w_rem_sh - {1'b0, r_b};
  assign w_div_next = w_diff[DATA_W]
                    ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                    : {w_diff[DATA_W-1:0],   r_acc[DATA_W-2:0], 1'b1};

  // ---------------- sign fix-up ----------------
  assign w_neg_res = r_sa ^ r_sb;
  assign w_prod    = w_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_hilo    = {r_hi, r_lo};
  assign w_acc_res = r_op[0] ? (w_hilo - w_prod) : (w_hilo + w_prod);
  assign w_quo     = w_neg_res ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0];
  assign w_rem     = r_sa ? (~r_acc[2*DATA_W-1:DATA_W] + 1'b1) : r_acc[2*DATA_W-1:DATA_W];

  always_comb begin
    w_fix_hi = r_acc[2*DATA_W-1:DATA_W];
    w_fix_lo = r_acc[DATA_W-1:0];
    if (r_op == 2'b01) begin
      if (r_dbz) begin
        // Divisor was zero: no iterations ran, so the low half still holds
        // |dividend|; re-apply the sign to return the original operand.
        w_fix_hi = r_sa ? (~r_acc[DATA_W-1:0] + 1'b1) : r_acc[DATA_W-1:0];
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
      end
    end else if (r_op[1]) begin
      w_fix_hi = w_acc_res[2*DATA_W-1:DATA_W];
      w_fix_lo = w_acc_res[DATA_W-1:0];
    end else begin
      w_fix_hi = w_prod[2*DATA_W-1:DATA_W];
      w_fix_lo = w_prod[DATA_W-1:0];
    end
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_div) w_next = w_in_dbz ? S_FIX : S_DIV;
          else          w_next = S_MUL;
        end
      end
      S_MUL, S_DIV: begin
        if (cancel_i)               w_next = S_IDLE;
        else if (r_cnt == LAST_CNT) w_next = S_FIX;
      end
      S_FIX:   w_next = cancel_i ? S_IDLE : S_DONE;
      S_DONE:  w_next = S_IDLE;   // start_i here is still the finished instruction
      default: w_next = S_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op   <= '0;
      r_cnt  <= '0;
      r_acc  <= '0;
      r_b    <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_dbz  <= 1'b0;
      r_hi_o <= '0;
      r_lo_o <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op  <= op_i[2:1];
            r_cnt <= '0;
            r_acc <= {{DATA_W{1'b0}}, w_mag_a};
            r_b   <= w_mag_b;
            r_sa  <= w_a_neg;
            r_sb  <= w_b_neg;
            r_hi  <= hi_i;
            r_lo  <= lo_i;
            r_dbz <= w_in_dbz;
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          if (!cancel_i) begin
            r_hi_o <= w_fix_hi;
            r_lo_o <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- outputs ----------------
  // rst gates stall_o so every output drops the moment reset asserts,
  // even while EX still presents start_i.
  assign stall_o = !rst && ((r_state == S_MUL) || (r_state == S_DIV) ||
                            (r_state == S_FIX) || w_accept);
  assign done_o  = (r_state == S_DONE) && !cancel_i;
  assign whilo_o = done_o;
  assign dbz_o   = (r_state == S_DONE) && r_dbz;
  assign hi_o    = r_hi_o;
  assign lo_o    = r_lo_o;

endmodule

// File: doc/ex_muldiv.md
Name: ex_muldiv

Overview:
- Iterative multiply/divide unit alongside the EX-stage ALU; produces {HI,LO} results for MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU.
- Holds the pipeline through stall_o while iterating, then issues a one-cycle HI/LO write request.
- Widths are parametrised; adds multi-cycle sequencing, accumulate modes and flush, none of which the single-cycle ALU path has.

Parameters:
DATA_W, 32, operand width; HI and LO are each DATA_W bits.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start_i  input  1  EX holds a mul/div op; held high while stalled.
op_i  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, 6 MSUB, 7 MSUBU.
opa_i  input  DATA_W  rs operand / dividend.
opb_i  input  DATA_W  rt operand / divisor.
hi_i  input  DATA_W  forwarded HI (MEM-forwarded value already selected).
lo_i  input  DATA_W  forwarded LO.
cancel_i  input  1  flush of the EX instruction.
stall_o  output  1  pipeline hold request (combinational).
done_o  output  1  one-cycle completion pulse.
whilo_o  output  1  HI/LO write enable; equals done_o.
hi_o  output  DATA_W  result HI.
lo_o  output  DATA_W  result LO.
dbz_o  output  1  divide-by-zero flag, valid with done_o.

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, datapath registers 0, every output 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE:
  - start_i && !cancel_i: latch op_i, |opa_i|, |opb_i| (magnitudes for signed ops), sign bits, hi_i and lo_i; counter = 0.
  - Next state: MUL for ops 0,1,4,5. For ops 2,3: FIX if opb_i==0, otherwise DIV.
- MUL: one shift-add step per cycle; DATA_W cycles, then FIX.
- DIV: one restoring step per cycle; DATA_W cycles, then FIX.
- FIX (1 cycle):
  - Negate the product if signs differ.
  - Signed divide: quotient sign = a^b, remainder sign = a.
  - MADD*/MSUB*: {HI,LO} = latched {hi,lo} ± product, modulo 2^(2*DATA_W).
  - Load hi_o/lo_o. Next state DONE.
- DONE (1 cycle): done_o=whilo_o=1, hi_o/lo_o stable. start_i is ignored, because it is the same instruction still held. Next state IDLE.
- Result mapping: multiply → HI = upper DATA_W bits, LO = lower. Divide → HI = remainder, LO = quotient.
- Latency: accept edge T → done_o high during cycle T+DATA_W+2 (34 cycles at 32). Divide-by-zero skips iterations: done at T+2.
- Divide by zero: HI = opa_i, LO = all ones, dbz_o=1 during DONE; otherwise dbz_o=0.
- Overflow case DIV(most-negative, -1): LO = most-negative, HI = 0. No trap.
- stall_o = (state ∈ {MUL,DIV,FIX}) || (state==IDLE && start_i && !cancel_i). It is low in DONE, so the pipeline advances at the end of DONE.
- hi_o/lo_o keep their last value in IDLE. whilo_o=0 outside DONE.
- cancel_i in MUL/DIV/FIX: next state IDLE, no done/whilo. cancel_i in DONE: whilo_o and done_o are forced to 0 that cycle.
- Back-to-back ops: a new start_i is accepted in the IDLE cycle immediately after DONE.

Test Plan:
- MULT 0xFFFFFFFE × 0x00000003 (DATA_W=32) → done at T+34: HI=0xFFFFFFFF, LO=0xFFFFFFFA. stall_o high cycles T..T+33, low at T+34.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001, whilo_o single-cycle pulse.
- DIV 0xFFFFFFF9 (-7) ÷ 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7 ÷ 0 → done at T+2, HI=7, LO=0xFFFFFFFF, dbz_o=1.
- MADD with hi_i=0, lo_i=0xFFFFFFFF, 1×1 → HI=1, LO=0. MSUB with hi_i=lo_i=0, 1×1 → HI=LO=0xFFFFFFFF.
- cancel_i at T+10 of a MULT → IDLE at T+11, no whilo_o ever, stall_o low from T+11. Async rst mid-DIV → all outputs 0 immediately, without waiting for a clock edge.
- Two MULTs back to back with start_i held continuously → exactly two done pulses 35 cycles apart. DATA_W=8 build, MULT 0x80×0xFF → HI=0x00, LO=0x80, done at T+10.
